// File: rtl/piso_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx_pkg
// Description : Shared types and defaults for the two-requester PISO
//               transmitter: the controller state enum, the default word
//               width and inter-word gap, and the gap counter width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package piso_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAPW  = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_GAP   = 0;

   // GAP is limited to 0..15, so four bits always hold the gap count
   localparam int GAP_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/piso_shift.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift
// Description : Parallel-load, MSB-first shift register. Load has priority
//               over shift; each shift moves the word one place toward the
//               MSB and fills the LSB with 0.
// Ports       : clk      - clock, rising edge
//               rst      - synchronous active-high reset, clears the register
//               load     - capture din this edge
//               shift_en - shift left by one this edge
//               din      - parallel word [WIDTH-1:0]
//               msb      - current MSB of the register
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] din,
   output logic             msb
);

   logic [WIDTH-1:0] sreg;

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg <= '0;
      end else if (load) begin
         sreg <= din;
      end else if (shift_en) begin
         sreg <= sreg << 1;
      end
   end

   assign msb = sreg[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/piso_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx_arb
// Description : Two-requester round-robin arbiter feeding a parallel-in
//               serial-out transmitter. A word is accepted only in IDLE, then
//               shifted out MSB first over WIDTH cycles, followed by GAP idle
//               cycles before the next acceptance.
// Ports       : clk, rst               - clock / synchronous active-high reset
//               req0_valid/data/ready  - requester 0 handshake
//               req1_valid/data/ready  - requester 1 handshake
//               so, so_valid, so_first - serial bit, bit valid, first bit
//               so_src                 - requester owning the word on so
//               busy                   - controller not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module piso_tx_arb
   import piso_tx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int GAP   = DEF_GAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             so,
   output logic             so_valid,
   output logic             so_first,
   output logic             so_src,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       bit_cnt, bit_cnt_nxt;
   logic [GAP_CNT_W-1:0]   gap_cnt, gap_cnt_nxt;
   logic                   last_grant, last_grant_nxt;
   logic                   src, src_nxt;
   logic                   grant1;
   logic                   idle_ok;
   logic                   take;
   logic                   shift_en;
   logic                   msb;
   logic                   in_shift;
   logic [WIDTH-1:0]       load_data;

   // Requester 1 wins when it is alone, or when both compete and requester 0
   // was served last.
   assign grant1     = req1_valid && (!req0_valid || !last_grant);
   assign idle_ok    = (state == IDLE) && !rst;
   assign req0_ready = idle_ok && req0_valid && !grant1;
   assign req1_ready = idle_ok && grant1;
   assign take       = req0_ready || req1_ready;
   assign load_data  = grant1 ? req1_data : req0_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         last_grant <= 1'b1;
         src        <= 1'b0;
      end else begin
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         gap_cnt    <= gap_cnt_nxt;
         last_grant <= last_grant_nxt;
         src        <= src_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      bit_cnt_nxt    = bit_cnt;
      gap_cnt_nxt    = gap_cnt;
      last_grant_nxt = last_grant;
      src_nxt        = src;
      shift_en       = 1'b0;
      case (state)
         IDLE: begin
            if (take) begin
               state_nxt      = SHIFT;
               bit_cnt_nxt    = CNT_W'(WIDTH);
               src_nxt        = grant1;
               last_grant_nxt = grant1;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            // bit_cnt counts bits still to present, including the current one
            if (bit_cnt == CNT_W'(1)) begin
               bit_cnt_nxt = '0;
               if (GAP > 0) begin
                  state_nxt   = GAPW;
                  gap_cnt_nxt = GAP_CNT_W'(GAP);
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               bit_cnt_nxt = bit_cnt - CNT_W'(1);
            end
         end
         GAPW: begin
            if (gap_cnt == GAP_CNT_W'(1)) begin
               state_nxt   = IDLE;
               gap_cnt_nxt = '0;
            end else begin
               gap_cnt_nxt = gap_cnt - GAP_CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   piso_shift #(
      .WIDTH (WIDTH)
   ) u_shift (
      .clk      (clk),
      .rst      (rst),
      .load     (take),
      .shift_en (shift_en),
      .din      (load_data),
      .msb      (msb)
   );

   // Outputs are forced quiet while rst is high, including the first reset
   // cycle before the state register has been cleared.
   assign in_shift = (state == SHIFT) && !rst;
   assign so       = in_shift && msb;
   assign so_valid = in_shift;
   assign so_first = in_shift && (bit_cnt == CNT_W'(WIDTH));
   assign so_src   = in_shift && src;
   assign busy     = (state != IDLE) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_piso_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_tx_arb
// Description : Self-checking bench for piso_tx_arb. One instance with GAP=0
//               is driven from a vector table and hand sequences, with its
//               serial output checked against a queue of expected words; a
//               second instance with GAP=2 is checked against a cycle trace.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx_arb;

   localparam int W = 4;

   typedef struct {
      logic         src;
      logic [W-1:0] data;
   } exp_t;

   typedef struct {
      logic         v0;
      logic         v1;
      logic [W-1:0] d0;
      logic [W-1:0] d1;
      logic         r0;
      logic         r1;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         v0, v1, rdy0, rdy1;
   logic [W-1:0] d0, d1;
   logic         so, so_valid, so_first, so_src, busy;

   logic         g_v0, g_v1, g_rdy0, g_rdy1;
   logic [W-1:0] g_d0, g_d1;
   logic         g_so, g_so_valid, g_so_first, g_so_src, g_busy;

   int n_checks = 0;
   int n_pass   = 0;

   exp_t exp_q[$];
   int   gaps[$];
   exp_t cur;
   int   bitpos   = 0;
   bit   in_word  = 1'b0;
   bit   have_prev = 1'b0;
   int   idle_run = 0;

   vec_t tbl[9];

   always #5 clk = ~clk;

   piso_tx_arb #(.WIDTH(W), .GAP(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (v0),
      .req0_data  (d0),
      .req0_ready (rdy0),
      .req1_valid (v1),
      .req1_data  (d1),
      .req1_ready (rdy1),
      .so         (so),
      .so_valid   (so_valid),
      .so_first   (so_first),
      .so_src     (so_src),
      .busy       (busy)
   );

   piso_tx_arb #(.WIDTH(W), .GAP(2)) dut_g2 (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (g_v0),
      .req0_data  (g_d0),
      .req0_ready (g_rdy0),
      .req1_valid (g_v1),
      .req1_data  (g_d1),
      .req1_ready (g_rdy1),
      .so         (g_so),
      .so_valid   (g_so_valid),
      .so_first   (g_so_first),
      .so_src     (g_so_src),
      .busy       (g_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
   endtask

   task automatic note_fail(input string name, input string what);
      n_checks++;
      $display("FAIL %s: got %s, expected none", name, what);
   endtask

   task automatic wait_idle(input int max_cycles);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < max_cycles) begin
         @(posedge clk); #1;
         n++;
      end
      chk("wait_idle_timeout", 32'(busy !== 1'b0), 0);
   endtask

   // Output-side scoreboard for the GAP=0 instance
   always @(negedge clk) begin
      if (rst) begin
         chk("reset_outputs", {25'd0, so, so_valid, so_first, so_src, busy, rdy0, rdy1}, 0);
         exp_q.delete();
         in_word   = 1'b0;
         have_prev = 1'b0;
         idle_run  = 0;
      end else if (so_valid) begin
         if (so_first) begin
            if (in_word) note_fail("word_truncated", "new first bit mid-word");
            if (have_prev) gaps.push_back(idle_run);
            if (exp_q.size() == 0) begin
               note_fail("unexpected_word", "word with empty queue");
               in_word = 1'b0;
            end else begin
               cur     = exp_q.pop_front();
               bitpos  = W - 1;
               in_word = 1'b1;
            end
         end
         if (!in_word) begin
            if (!so_first) note_fail("stray_bit", "so_valid without a word");
         end else begin
            chk("so_bit", 32'(so), 32'(cur.data[bitpos]));
            chk("so_src", 32'(so_src), 32'(cur.src));
            if (bitpos == 0) begin
               in_word   = 1'b0;
               have_prev = 1'b1;
            end else begin
               bitpos--;
            end
         end
         idle_run = 0;
      end else begin
         if (in_word) note_fail("word_broken", "so_valid dropped mid-word");
         in_word = 1'b0;
         idle_run++;
         chk("idle_outputs", {29'd0, so, so_first, so_src}, 0);
      end
   end

   initial begin
      int hs;
      logic [13:0] tr_v, tr_b, tr_s, tr_f;

      tbl[0] = '{1'b1, 1'b0, 4'b1010, 4'b0000, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 4'b1100, 4'b0011, 1'b0, 1'b1};
      tbl[2] = '{1'b1, 1'b1, 4'b1100, 4'b0011, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 4'b0000, 4'b0110, 1'b0, 1'b1};
      tbl[4] = '{1'b0, 1'b1, 4'b0000, 4'b1001, 1'b0, 1'b1};
      tbl[5] = '{1'b1, 1'b1, 4'b0111, 4'b1000, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0};
      tbl[8] = '{1'b1, 1'b1, 4'b0001, 4'b1110, 1'b0, 1'b1};

      // Reset held for three cycles with both requesters valid
      rst = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 4'b1010; d1 = 4'b0101;
      g_v0 = 1'b0; g_v1 = 1'b0; g_d0 = 4'b1010; g_d1 = 4'b0000;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #2;
         chk("rst_ready", {30'd0, rdy0, rdy1}, 0);
         chk("rst_so_valid_busy", {30'd0, so_valid, busy}, 0);
      end
      @(posedge clk); #1;
      rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
      #1;
      chk("post_rst_quiet", {28'd0, so, so_valid, so_src, busy}, 0);

      // Vector table: one word per record, grant predicted per record
      for (int i = 0; i < 9; i++) begin
         wait_idle(40);
         v0 = tbl[i].v0; v1 = tbl[i].v1; d0 = tbl[i].d0; d1 = tbl[i].d1;
         #1;
         chk($sformatf("tbl%0d_ready0", i), 32'(rdy0), 32'(tbl[i].r0));
         chk($sformatf("tbl%0d_ready1", i), 32'(rdy1), 32'(tbl[i].r1));
         if (tbl[i].r0 || tbl[i].r1)
            exp_q.push_back('{src: tbl[i].r1, data: (tbl[i].r1 ? tbl[i].d1 : tbl[i].d0)});
         @(posedge clk); #1;
         v0 = 1'b0; v1 = 1'b0;
      end
      wait_idle(40);

      // Back-to-back contention: grant order 0,1,0,1 with one idle cycle between words
      gaps.delete();
      have_prev = 1'b0;
      v0 = 1'b1; v1 = 1'b1; d0 = 4'b1100; d1 = 4'b0011;
      exp_q.push_back('{src: 1'b0, data: 4'b1100});
      exp_q.push_back('{src: 1'b1, data: 4'b0011});
      exp_q.push_back('{src: 1'b0, data: 4'b1100});
      exp_q.push_back('{src: 1'b1, data: 4'b0011});
      hs = 0;
      for (int c = 0; c < 60 && hs < 4; c++) begin
         #1;
         if ((v0 && rdy0) || (v1 && rdy1)) hs++;
         @(posedge clk); #1;
         if (hs == 4) begin
            v0 = 1'b0; v1 = 1'b0;
         end
      end
      v0 = 1'b0; v1 = 1'b0;
      chk("b2b_handshakes", 32'(hs), 4);
      wait_idle(40);
      chk("b2b_gap_count", 32'(gaps.size()), 3);
      for (int g = 0; g < 3; g++) begin
         if (g < gaps.size()) chk($sformatf("b2b_gap%0d", g), 32'(gaps[g]), 1);
      end

      // Reset after two bits of 1010: remaining bits dropped, requester 0 re-wins
      v0 = 1'b1; v1 = 1'b1; d0 = 4'b1010; d1 = 4'b0101;
      exp_q.push_back('{src: 1'b0, data: 4'b1010});
      #1;
      chk("abort_grant", {30'd0, rdy0, rdy1}, 32'b10);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_so_valid_in_rst", 32'(so_valid), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("abort_so_valid_after", 32'(so_valid), 0);
      chk("abort_busy_after", 32'(busy), 0);
      chk("abort_regrant", {30'd0, rdy0, rdy1}, 32'b10);
      exp_q.push_back('{src: 1'b0, data: 4'b1010});
      @(posedge clk); #1;
      v0 = 1'b0; v1 = 1'b0;
      wait_idle(40);

      // Requester 1 pulses for one cycle while a word is shifting
      v0 = 1'b1; d0 = 4'b1111;
      exp_q.push_back('{src: 1'b0, data: 4'b1111});
      @(posedge clk); #1;
      v0 = 1'b0;
      @(posedge clk); #1;
      v1 = 1'b1; d1 = 4'b0110;
      #1;
      chk("pulse_ready1", 32'(rdy1), 0);
      @(posedge clk); #1;
      v1 = 1'b0;
      wait_idle(40);
      repeat (6) @(posedge clk);
      #1;
      chk("pulse_no_word", 32'(exp_q.size()), 0);
      chk("pulse_idle", 32'(busy), 0);

      // GAP=2 instance: requester 0 back-to-back, cycle trace from the transfer edge
      g_v0 = 1'b1;
      #1;
      chk("g2_ready0", 32'(g_rdy0), 1);
      for (int j = 0; j < 14; j++) begin
         @(posedge clk); #1;
         if (j == 7) g_v0 = 1'b0;
         #1;
         tr_v[j] = g_so_valid;
         tr_b[j] = g_busy;
         tr_s[j] = g_so;
         tr_f[j] = g_so_first;
      end
      g_v0 = 1'b0;
      chk("g2_so_valid_trace", 32'(tr_v), 32'(14'b000_1111_000_1111));
      chk("g2_busy_trace",     32'(tr_b), 32'(14'b0111111_0111111));
      chk("g2_so_trace",       32'(tr_s), 32'(14'b000_0101_000_0101));
      chk("g2_so_first_trace", 32'(tr_f), 32'(14'b000_0001_000_0001));

      chk("final_queue_empty", 32'(exp_q.size()), 0);
      chk("final_word_closed", 32'(in_word), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
